// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: operand fetch with writeback bypass, an in-flight
// destination scoreboard for RAW/WAW blocking, and a registered valid/ready output.
module reg_read_stage #(
  parameter  int XLEN      = 64,
  parameter  int NREGS     = 16,
  parameter  int NSRC      = 2,
  parameter  int PAYLOAD_W = 512,
  parameter  int SP_REG    = 4,
  localparam int RW        = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*RW-1:0]     src_idx_in,
  input  logic [NSRC-1:0]        src_valid_in,
  input  logic                   implicit_sp_in,
  input  logic [RW-1:0]          dst_idx_in,
  input  logic                   dst_valid_in,
  input  logic [PAYLOAD_W-1:0]   payload_in,
  input  logic [NREGS*XLEN-1:0]  regfile_in,
  input  logic                   wb_valid,
  input  logic [RW-1:0]          wb_idx,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NSRC*XLEN-1:0]   operand_out,
  output logic [NSRC*RW-1:0]     src_idx_out,
  output logic [NSRC-1:0]        src_valid_out,
  output logic [RW-1:0]          dst_idx_out,
  output logic                   dst_valid_out,
  output logic [XLEN-1:0]        dst_val_out,
  output logic                   mem_src0_out,
  output logic [PAYLOAD_W-1:0]   payload_out,
  output logic                   hazard_out
);

  localparam logic [RW-1:0] SpIdx = RW'(SP_REG);

  logic                  outValidQ;
  logic [NREGS-1:0]      pendingQ;
  logic [NREGS-1:0]      pendingNext;
  logic [NSRC*RW-1:0]    effIdx;
  logic [NSRC-1:0]       effValid;
  logic [NSRC*XLEN-1:0]  operandNext;
  logic [XLEN-1:0]       dstValNext;
  logic                  srcBlocked;
  logic                  dstBlocked;
  logic                  hazard;
  logic                  slotFree;
  logic                  accept;

  // Same-cycle writeback takes precedence over the (stale) register-file copy.
  function automatic logic [XLEN-1:0] readReg(
    input logic [RW-1:0]         r,
    input logic                  wbV,
    input logic [RW-1:0]         wbI,
    input logic [XLEN-1:0]       wbD,
    input logic [NREGS*XLEN-1:0] rf
  );
    if (wbV && (wbI == r)) return wbD;
    return rf[int'(r)*XLEN +: XLEN];
  endfunction

  always_comb begin
    effIdx   = src_idx_in;
    effValid = src_valid_in;
    if (implicit_sp_in) begin
      effIdx[RW-1:0] = SpIdx;
      effValid[0]    = 1'b1;
    end
  end

  // A pending register being written back this cycle is no longer a hazard.
  always_comb begin
    srcBlocked  = 1'b0;
    operandNext = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (effValid[k]) begin
        operandNext[k*XLEN +: XLEN] =
          readReg(effIdx[k*RW +: RW], wb_valid, wb_idx, wb_data, regfile_in);
        if (pendingQ[effIdx[k*RW +: RW]] && !(wb_valid && (wb_idx == effIdx[k*RW +: RW])))
          srcBlocked = 1'b1;
      end
    end
  end

  always_comb begin
    dstBlocked = dst_valid_in && pendingQ[dst_idx_in] && !(wb_valid && (wb_idx == dst_idx_in));
    dstValNext = dst_valid_in ? readReg(dst_idx_in, wb_valid, wb_idx, wb_data, regfile_in) : '0;
    hazard     = in_valid && (srcBlocked || dstBlocked);
    slotFree   = !outValidQ || out_ready;
    in_ready   = !reset && !flush && !hazard && slotFree;
    hazard_out = hazard && slotFree;
    accept     = in_valid && in_ready;
  end

  // Clear from writeback first so a same-index set from an accept wins.
  always_comb begin
    pendingNext = pendingQ;
    if (wb_valid) pendingNext[wb_idx] = 1'b0;
    if (accept && dst_valid_in) pendingNext[dst_idx_in] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValidQ     <= 1'b0;
      pendingQ      <= '0;
      operand_out   <= '0;
      src_idx_out   <= '0;
      src_valid_out <= '0;
      dst_idx_out   <= '0;
      dst_valid_out <= 1'b0;
      dst_val_out   <= '0;
      mem_src0_out  <= 1'b0;
      payload_out   <= '0;
    end else if (flush) begin
      outValidQ <= 1'b0;
      pendingQ  <= '0;
    end else begin
      pendingQ <= pendingNext;
      if (accept) begin
        outValidQ     <= 1'b1;
        operand_out   <= operandNext;
        src_idx_out   <= effIdx;
        src_valid_out <= effValid;
        dst_idx_out   <= dst_idx_in;
        dst_valid_out <= dst_valid_in;
        dst_val_out   <= dstValNext;
        mem_src0_out  <= implicit_sp_in;
        payload_out   <= payload_in;
      end else if (outValidQ && out_ready) begin
        outValidQ <= 1'b0;
      end
    end
  end

  assign out_valid = outValidQ;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios plus randomized traffic against a
// behavioural model of the scoreboard and output register.
module tb_reg_read_stage;

  localparam int XLEN = 64;
  localparam int NREGS = 16;
  localparam int NSRC = 2;
  localparam int PW = 512;
  localparam int RW = 4;
  localparam int SP = 4;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready;
  logic [NSRC*RW-1:0] src_idx_in;
  logic [NSRC-1:0] src_valid_in;
  logic implicit_sp_in;
  logic [RW-1:0] dst_idx_in;
  logic dst_valid_in;
  logic [PW-1:0] payload_in;
  logic [NREGS*XLEN-1:0] regfile_in;
  logic wb_valid;
  logic [RW-1:0] wb_idx;
  logic [XLEN-1:0] wb_data;
  logic out_valid, out_ready;
  logic [NSRC*XLEN-1:0] operand_out;
  logic [NSRC*RW-1:0] src_idx_out;
  logic [NSRC-1:0] src_valid_out;
  logic [RW-1:0] dst_idx_out;
  logic dst_valid_out;
  logic [XLEN-1:0] dst_val_out;
  logic mem_src0_out;
  logic [PW-1:0] payload_out;
  logic hazard_out;

  logic [XLEN-1:0] rf [NREGS];

  reg_read_stage #(.XLEN(XLEN), .NREGS(NREGS), .NSRC(NSRC), .PAYLOAD_W(PW), .SP_REG(SP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_idx_in(src_idx_in), .src_valid_in(src_valid_in), .implicit_sp_in(implicit_sp_in),
    .dst_idx_in(dst_idx_in), .dst_valid_in(dst_valid_in), .payload_in(payload_in),
    .regfile_in(regfile_in), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .operand_out(operand_out),
    .src_idx_out(src_idx_out), .src_valid_out(src_valid_out), .dst_idx_out(dst_idx_out),
    .dst_valid_out(dst_valid_out), .dst_val_out(dst_val_out), .mem_src0_out(mem_src0_out),
    .payload_out(payload_out), .hazard_out(hazard_out)
  );

  always #5 clk = ~clk;

  always_comb
    for (int r = 0; r < NREGS; r++) regfile_in[r*XLEN +: XLEN] = rf[r];

  int total = 0;
  int bad = 0;

  // Reference model state
  bit pend [NREGS];
  bit mOV;
  logic [XLEN-1:0] mOp [NSRC];
  logic [RW-1:0] mSrc [NSRC];
  bit mSv [NSRC];
  logic [RW-1:0] mDst;
  bit mDv;
  logic [XLEN-1:0] mDval;
  bit mMem;
  logic [PW-1:0] mPay;

  function automatic logic [XLEN-1:0] rd(input logic [RW-1:0] r);
    if (wb_valid && wb_idx == r) return wb_data;
    return rf[r];
  endfunction

  function automatic logic [RW-1:0] slotIdx(input int k);
    if (k == 0 && implicit_sp_in) return 4'(SP);
    return src_idx_in[k*RW +: RW];
  endfunction

  function automatic bit slotValid(input int k);
    if (k == 0 && implicit_sp_in) return 1'b1;
    return src_valid_in[k];
  endfunction

  function automatic bit mHaz();
    if (!in_valid) return 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (slotValid(k) && pend[slotIdx(k)] && !(wb_valid && wb_idx == slotIdx(k))) return 1'b1;
    if (dst_valid_in && pend[dst_idx_in] && !(wb_valid && wb_idx == dst_idx_in)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mRdy();
    return !reset && !flush && !mHaz() && (!mOV || out_ready);
  endfunction

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    bit acc, rs, fl, wv, dv, imp, ordy;
    logic [RW-1:0] wi, dst;
    logic [PW-1:0] pay;
    logic [XLEN-1:0] nOp [NSRC];
    logic [RW-1:0] nIdx [NSRC];
    bit nV [NSRC];
    logic [XLEN-1:0] nDval;
    acc = in_valid && mRdy();
    for (int k = 0; k < NSRC; k++) begin
      nIdx[k] = slotIdx(k);
      nV[k] = slotValid(k);
      nOp[k] = nV[k] ? rd(nIdx[k]) : '0;
    end
    nDval = dst_valid_in ? rd(dst_idx_in) : '0;
    rs = reset; fl = flush; wv = wb_valid; wi = wb_idx; dst = dst_idx_in;
    dv = dst_valid_in; imp = implicit_sp_in; pay = payload_in; ordy = out_ready;
    @(posedge clk);
    if (rs) begin
      mOV = 0; mDst = '0; mDv = 0; mDval = '0; mMem = 0; mPay = '0;
      for (int r = 0; r < NREGS; r++) pend[r] = 0;
      for (int k = 0; k < NSRC; k++) begin mOp[k] = '0; mSrc[k] = '0; mSv[k] = 0; end
    end else if (fl) begin
      mOV = 0;
      for (int r = 0; r < NREGS; r++) pend[r] = 0;
    end else begin
      if (wv) pend[wi] = 0;
      if (acc) begin
        for (int k = 0; k < NSRC; k++) begin mOp[k] = nOp[k]; mSrc[k] = nIdx[k]; mSv[k] = nV[k]; end
        mDst = dst; mDv = dv; mDval = nDval; mMem = imp; mPay = pay;
        if (dv) pend[dst] = 1;
        mOV = 1;
      end else if (mOV && ordy) begin
        mOV = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; wb_valid = 0; wb_idx = '0; wb_data = '0; out_ready = 1;
    implicit_sp_in = 0; src_idx_in = '0; src_valid_in = '0; dst_idx_in = '0; dst_valid_in = 0;
  endtask

  task automatic offer(input logic [RW-1:0] s0, input bit v0, input logic [RW-1:0] s1,
                       input bit v1, input logic [RW-1:0] d, input bit dv);
    in_valid = 1;
    src_idx_in = {s1, s0};
    src_valid_in = {v1, v0};
    dst_idx_in = d;
    dst_valid_in = dv;
    for (int i = 0; i < PW/32; i++) payload_in[i*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    offer(4'd1, 1, 4'd2, 1, 4'd3, 1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (operand_out !== '0 || dst_val_out !== '0 || payload_out !== '0)
      begin bad++; $display("FAIL reset_data got=%h/%h want=0", operand_out, dst_val_out); end
    total++; if (src_idx_out !== '0 || src_valid_out !== '0 || dst_idx_out !== '0 || dst_valid_out !== 1'b0 || mem_src0_out !== 1'b0)
      begin bad++; $display("FAIL reset_fields got=%h %b %h %b %b want=0", src_idx_out, src_valid_out, dst_idx_out, dst_valid_out, mem_src0_out); end
    reset = 0;
    idle();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    rf[1] = 64'h11; rf[2] = 64'h22; rf[3] = 64'h33;
    offer(4'd1, 1, 4'd2, 1, 4'd3, 1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (operand_out !== {64'h22, 64'h11}) begin bad++; $display("FAIL basic_operands got=%h want=%h", operand_out, {64'h22, 64'h11}); end
    total++; if (dst_idx_out !== 4'd3 || dst_valid_out !== 1'b1 || dst_val_out !== 64'h33)
      begin bad++; $display("FAIL basic_dst got=%h %b %h want=3 1 33", dst_idx_out, dst_valid_out, dst_val_out); end
  endtask

  task automatic test_raw();
    offer(4'd3, 1, 4'd0, 0, 4'd6, 1);
    #1;
    total++; if (in_ready !== 1'b0 || hazard_out !== 1'b1)
      begin bad++; $display("FAIL raw_block got=%b/%b want=0/1", in_ready, hazard_out); end
    tick();
    wb_valid = 1; wb_idx = 4'd3; wb_data = 64'h99;
    #1;
    total++; if (in_ready !== 1'b1 || hazard_out !== 1'b0)
      begin bad++; $display("FAIL raw_wb_unblock got=%b/%b want=1/0", in_ready, hazard_out); end
    tick();
    total++; if (operand_out !== {64'h0, 64'h99}) begin bad++; $display("FAIL raw_bypass got=%h want=%h", operand_out, {64'h0, 64'h99}); end
    wb_valid = 0;
    offer(4'd3, 1, 4'd0, 0, 4'd0, 0);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL raw_cleared got=%b want=1", in_ready); end
    tick();
  endtask

  task automatic test_sp();
    rf[4] = 64'h7FF0;
    offer(4'd9, 0, 4'd1, 1, 4'd0, 0);
    implicit_sp_in = 1;
    payload_in[7:0] = 8'hC3;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sp_ready got=%b want=1", in_ready); end
    tick();
    implicit_sp_in = 0;
    total++; if (operand_out !== {64'h11, 64'h7FF0}) begin bad++; $display("FAIL sp_operands got=%h want=%h", operand_out, {64'h11, 64'h7FF0}); end
    total++; if (src_idx_out[3:0] !== 4'd4 || src_valid_out[0] !== 1'b1 || mem_src0_out !== 1'b1)
      begin bad++; $display("FAIL sp_fields got=%h %b %b want=4 1 1", src_idx_out[3:0], src_valid_out[0], mem_src0_out); end
    total++; if (payload_out[7:0] !== 8'hC3) begin bad++; $display("FAIL sp_payload got=%h want=c3", payload_out[7:0]); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    offer(4'd1, 1, 4'd2, 1, 4'd0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || operand_out !== {64'h11, 64'h7FF0} || mem_src0_out !== 1'b1)
        begin bad++; $display("FAIL bp_hold got=%b %h %b want=1 %h 1", out_valid, operand_out, mem_src0_out, {64'h11, 64'h7FF0}); end
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", in_ready); end
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || operand_out !== {64'h22, 64'h11} || mem_src0_out !== 1'b0)
      begin bad++; $display("FAIL bp_next got=%b %h %b want=1 %h 0", out_valid, operand_out, mem_src0_out, {64'h22, 64'h11}); end
  endtask

  task automatic test_set_wins();
    offer(4'd0, 0, 4'd0, 0, 4'd5, 1);
    wb_valid = 1; wb_idx = 4'd5; wb_data = 64'h55;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL setwins_ready got=%b want=1", in_ready); end
    tick();
    wb_valid = 0;
    offer(4'd5, 1, 4'd0, 0, 4'd0, 0);
    #1;
    total++; if (in_ready !== 1'b0 || hazard_out !== 1'b1)
      begin bad++; $display("FAIL setwins_pending got=%b/%b want=0/1", in_ready, hazard_out); end
    tick();
    in_valid = 0;
  endtask

  task automatic test_flush();
    offer(4'd0, 0, 4'd0, 0, 4'd7, 1);
    #1;
    tick();
    offer(4'd5, 1, 4'd7, 1, 4'd6, 1);
    flush = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", in_ready); end
    tick();
    flush = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    #1;
    total++; if (in_ready !== 1'b1 || hazard_out !== 1'b0)
      begin bad++; $display("FAIL flush_cleared got=%b/%b want=1/0", in_ready, hazard_out); end
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_accept got=%b want=1", out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) rf[8+i] = 64'h1000 + 64'(i);
    for (int i = 0; i < 4; i++) begin
      offer(4'(8+i), 1, 4'(11-i), 1, 4'd0, 0);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || operand_out !== {64'h1000 + 64'(3-i), 64'h1000 + 64'(i)})
        begin bad++; $display("FAIL b2b_out[%0d] got=%b %h", i, out_valid, operand_out); end
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, NREGS-1)] = {$urandom, $urandom};
      offer(4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
            4'($urandom_range(0, 15)), 1'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      implicit_sp_in = ($urandom_range(0, 7) == 0);
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_idx = 4'($urandom_range(0, 15));
      wb_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      #1;
      total++; if (in_ready !== mRdy()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", n, in_ready, mRdy()); end
      total++; if (hazard_out !== (mHaz() && (!mOV || out_ready)))
        begin bad++; $display("FAIL rnd_hazard[%0d] got=%b want=%b", n, hazard_out, mHaz() && (!mOV || out_ready)); end
      tick();
      total++; if (out_valid !== mOV) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, out_valid, mOV); end
      total++; if (operand_out !== {mOp[1], mOp[0]})
        begin bad++; $display("FAIL rnd_operands[%0d] got=%h want=%h", n, operand_out, {mOp[1], mOp[0]}); end
      total++; if (src_idx_out !== {mSrc[1], mSrc[0]} || src_valid_out !== {mSv[1], mSv[0]} || mem_src0_out !== mMem)
        begin bad++; $display("FAIL rnd_src[%0d] got=%h %b %b want=%h %b %b", n, src_idx_out, src_valid_out, mem_src0_out, {mSrc[1], mSrc[0]}, {mSv[1], mSv[0]}, mMem); end
      total++; if (dst_idx_out !== mDst || dst_valid_out !== mDv || (mDv && dst_val_out !== mDval))
        begin bad++; $display("FAIL rnd_dst[%0d] got=%h %b %h want=%h %b %h", n, dst_idx_out, dst_valid_out, dst_val_out, mDst, mDv, mDval); end
      total++; if (payload_out !== mPay) begin bad++; $display("FAIL rnd_payload[%0d] got=%h want=%h", n, payload_out[63:0], mPay[63:0]); end
    end
    idle();
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) rf[r] = 64'h0;
    payload_in = '0;
    test_reset();
    test_basic();
    test_raw();
    test_sp();
    test_backpressure();
    test_set_wins();
    test_flush();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Parametrised register-read pipeline stage between decode and execute. It reads up to NSRC source operands plus the destination's old value from the architectural register file, forwards same-cycle writeback data, and tracks in-flight destinations in a scoreboard to block RAW/WAW hazards. Results are held in an output pipeline register with a valid/ready handshake, replacing the earlier purely combinational read step and its stall wiring.

## Interface

- XLEN, 64, register width in bits
- NREGS, 16, architectural register count; RW = $clog2(NREGS)
- NSRC, 2, source operands per instruction (1..4)
- PAYLOAD_W, 512, opaque decode fields passed through unchanged
- SP_REG, 4, register index read when implicit_sp_in is set (RETQ/POP)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discards the held instruction and clears the scoreboard
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- src_idx_in  in  NSRC*RW  source register indices; slot k at bits [k*RW +: RW]
- src_valid_in  in  NSRC  per-slot source valid
- implicit_sp_in  in  1  overrides slot 0 with SP_REG, valid, and sets mem_src0_out
- dst_idx_in  in  RW  destination index
- dst_valid_in  in  1  destination valid
- payload_in  in  PAYLOAD_W  pass-through fields
- regfile_in  in  NREGS*XLEN  flat register file; reg r at [r*XLEN +: XLEN]
- wb_valid  in  1  writeback this cycle
- wb_idx  in  RW  writeback register
- wb_data  in  XLEN  writeback value
- out_valid  out  1  held instruction valid
- out_ready  in  1  execute accepts
- operand_out  out  NSRC*XLEN  operand values, same slot packing
- src_idx_out / src_valid_out  out  NSRC*RW / NSRC  registered copies (after SP override)
- dst_idx_out / dst_valid_out  out  RW / 1  registered copies
- dst_val_out  out  XLEN  old value of destination
- mem_src0_out  out  1  slot 0 is a memory address (implicit_sp_in registered)
- payload_out  out  PAYLOAD_W  registered payload
- hazard_out  out  1  in_valid held off only by scoreboard (perf counter hook)

## Operation

- Effective slot 0: if implicit_sp_in, index = SP_REG and valid = 1; else the input fields.
- Read value for register r: wb_data if wb_valid && wb_idx == r, else regfile_in slice r.
- Scoreboard pending[NREGS]. hazard = in_valid && (any valid slot k with pending[idx_k] && !(wb_valid && wb_idx == idx_k), or dst_valid_in && pending[dst_idx_in] && !(wb_valid && wb_idx == dst_idx_in)).
- in_ready = !reset && !flush && !hazard && (!out_valid || out_ready). hazard_out = hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): load every output register; out_valid <= 1; if dst_valid_in, pending[dst_idx_in] <= 1. Invalid slots load operand 0.
- Every cycle with wb_valid: pending[wb_idx] <= 0. If an accept sets the same index in that cycle, the set wins.
- out_valid && out_ready without accept: out_valid <= 0; data registers hold.
- flush: out_valid <= 0, all pending <= 0, no accept that cycle; takes priority over wb and accept.
- Index compares are RW wide; register-file slicing never wraps because RW covers NREGS.

## Timing

- Reset: out_valid 0, pending all 0, operand_out/dst_val_out/payload_out/index/valid outputs 0, mem_src0_out 0; in_ready 0 while reset is high.
- Latency 1 cycle: input accepted at edge N appears on outputs after edge N.
- Full throughput: back-to-back accepts while out_ready = 1 and no hazard.
- in_ready is combinational from in_valid, out_valid, out_ready, wb_*, and pending; no combinational path from out_ready to out_valid.
- Outputs stay stable while out_valid && !out_ready.
- Reset or flush in the middle of a backpressured hold drops the instruction; there is no replay.

## Test plan

- Reset, then in_valid with src r1, r2 (regfile r1=0x11, r2=0x22), dst r3 -> next cycle out_valid=1, operand_out={0x22,0x11}, pending[3]=1.
- Then a dependent instruction with src r3 while r3 pending -> in_ready=0, hazard_out=1; wb_valid r3=0x99 in the same cycle -> accepted, operand slot 0=0x99, pending[3] cleared.
- implicit_sp_in=1, opcode payload C3, regfile r4=0x7FF0 -> operand slot 0=0x7FF0, src_idx_out slot 0=4, mem_src0_out=1.
- out_ready=0 for 3 cycles with in_valid high -> in_ready=0 and outputs unchanged; out_ready=1 -> next instruction loads on the following edge.
- Accept dst r5 while wb_valid r5 in the same cycle -> pending[5]=1 (set wins).
- Two pending registers plus flush -> out_valid=0, pending all 0, in_ready returns to 1 the next cycle.
